generate_ena_write_mc: RTL and testbench
========================================

# generate_ena_write_mc

Multi-channel, parametrised write-enable window generator for the OPT datapath. Each channel turns a trigger on its `d` input into a registered `q` enable that stays high for a programmable number of clock cycles. On top of the fixed single-channel level-triggered behaviour, each channel adds:

- run-time window length,
- edge or level triggering,
- optional retrigger (window extension),
- optional "skip first trigger after user reset" arming,
- a `done` pulse at the end of each window.

## Interface

Parameters:

- `CH`, 4: number of independent channels (≥1).
- `CNT_W`, 16: window-length / counter width; maximum length 2^CNT_W−1.

Ports:

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rst_user`  in  1  synchronous, active-high; clears every channel's `armed` flag only.
- `d`  in  CH  per-channel trigger.
- `cfg_len`  in  CH*CNT_W  window length L per channel; channel i uses bits [i*CNT_W +: CNT_W].
- `cfg_edge`  in  CH  1: rising-edge trigger; 0: level trigger.
- `cfg_retrig`  in  CH  1: a trigger during an active window restarts it.
- `cfg_skip_first`  in  CH  1: the first accepted trigger after reset or `rst_user` only arms the channel and produces no window.
- `q`  out  CH  registered write enable.
- `busy`  out  CH  equals `q`; provided for status readback.
- `done`  out  CH  registered one-cycle pulse when a window ends.

## Operation

Per-channel state:

- `cnt[CNT_W-1:0]`
- `len_l` (length latched at trigger)
- `q_r`, `done_r`, `armed`, `d_prev`

Trigger detection:

- `trig = cfg_edge ? (d & ~d_prev) : d`
- `d_prev` registers `d` every cycle.

Configuration is sampled at trigger acceptance only. Changing `cfg_len` mid-window has no effect on the running window.

States (IDLE when `q_r`=0, ACTIVE when `q_r`=1). Default each cycle: `done_r`<=0.

IDLE:
- `trig` and `cfg_len`=0: ignored; no window and no arming.
- `trig`, `cfg_skip_first`=1, `armed`=0: `armed`<=1; stay IDLE.
- `trig` otherwise: `q_r`<=1, `cnt`<=1, `len_l`<=`cfg_len`.

ACTIVE:
- `trig` with `cfg_retrig`=1 and `cfg_len`≠0: `cnt`<=1, `len_l`<=`cfg_len`, `q_r` stays 1. This has priority over expiry.
- Else if `cnt` < `len_l`: `cnt`<=`cnt`+1.
- Else (`cnt`==`len_l`): `q_r`<=0, `cnt`<=0, `done_r`<=1.
- When `cfg_retrig`=0, triggers during ACTIVE are dropped. Edges are still tracked in `d_prev`.

Other rules:

- `rst_user` clears `armed` in every channel. It has no effect on `q_r`/`cnt` of running windows. If it coincides with a skip-arming trigger, `rst_user` wins and `armed` stays 0.
- Channels are fully independent; there is no shared arbitration.
- Counter arithmetic is unsigned CNT_W-bit. `cnt` never exceeds `len_l`, so no wrap-around is possible.

## Timing

- Reset values (`rst_n` low, asynchronous): `q`=0, `busy`=0, `done`=0, `cnt`=0, `len_l`=0, `armed`=0, `d_prev`=0.
- Latency: a trigger sampled at edge k gives `q` high from edge k to edge k+L, i.e. exactly L cycles.
- `done` is high for the single cycle after the last `q` cycle, coincident with the first low `q` cycle.
- Non-retrigger mode enforces a one-cycle minimum gap between windows. The earliest new acceptance is the edge after `q` falls.
- Level mode with `d` held high therefore gives a repeating pattern of L cycles high, 1 cycle low.
- Retrigger at edge j gives `q` high through edge j+L, with no `done` for the extended window until it finally ends.
- `rst_n` asserted mid-window: `q` drops asynchronously and `done` is not issued.
- L=1 gives a one-cycle pulse on `q`.

## Test plan

- Ch0, level mode, L=3, `d`=1 for one cycle at edge 5: `q` high edges 5–8, i.e. 3 cycles; `done` pulse 1 cycle after `q` falls; other channels stay 0.
- Level mode, L=2, `d` held high for 10 cycles: `q` pattern 1,1,0,1,1,0,…; `done` at every fall.
- Edge mode, L=4, `d` held high for 20 cycles: exactly one 4-cycle window; a second rising edge produces a second window.
- Retrigger on, L=5, second trigger 3 cycles into the window: `q` high for 8 contiguous cycles total; single `done`. The same stimulus with retrigger off gives 5 cycles.
- `cfg_skip_first`=1, L=2, three separated triggers: first trigger gives no `q`, second and third give 2-cycle windows. After a `rst_user` pulse, the next trigger again gives no `q`.
- `rst_n` pulled low 2 cycles into an L=10 window: `q`/`done` go 0 immediately. A `cfg_len`=0 trigger afterwards gives no `q`, no `done`, and no arming.

Source files
------------

// File: rtl/generate_ena_write_mc.sv
// Per-channel write-enable window generator: a trigger on d opens a q window of cfg_len cycles.
// Latency: q rises on the edge that samples the trigger, stays high L cycles, done pulses on the first low cycle.
// Backpressure: none; triggers arriving while a window runs are dropped unless retrigger is enabled.
module generate_ena_write_mc #(
  parameter int CH    = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst_user,
  input  logic [CH-1:0]         d,
  input  logic [CH*CNT_W-1:0]   cfg_len,
  input  logic [CH-1:0]         cfg_edge,
  input  logic [CH-1:0]         cfg_retrig,
  input  logic [CH-1:0]         cfg_skip_first,
  output logic [CH-1:0]         q,
  output logic [CH-1:0]         busy,
  output logic [CH-1:0]         done
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    state_e           state;
    logic             done;
    logic             armed;
    logic             d_prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_l;
  } ch_t;

  ch_t              st     [CH];
  ch_t              st_nxt [CH];
  logic [CH-1:0]    trig;
  logic [CNT_W-1:0] len    [CH];

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign len[i]  = cfg_len[i*CNT_W +: CNT_W];
    assign trig[i] = cfg_edge[i] ? (d[i] & ~st[i].d_prev) : d[i];
    assign q[i]    = (st[i].state == ACTIVE);
    assign busy[i] = (st[i].state == ACTIVE);
    assign done[i] = st[i].done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) st[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) st[i] <= st_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      st_nxt[i]        = st[i];
      st_nxt[i].done   = 1'b0;
      st_nxt[i].d_prev = d[i];
      case (st[i].state)
        IDLE: begin
          // A zero-length trigger neither opens a window nor arms the channel.
          if (trig[i] && (len[i] != '0)) begin
            if (cfg_skip_first[i] && !st[i].armed) begin
              st_nxt[i].armed = 1'b1;
            end else begin
              st_nxt[i].state = ACTIVE;
              st_nxt[i].cnt   = CNT_W'(1);
              st_nxt[i].len_l = len[i];
            end
          end
        end
        ACTIVE: begin
          if (trig[i] && cfg_retrig[i] && (len[i] != '0)) begin
            st_nxt[i].cnt   = CNT_W'(1);
            st_nxt[i].len_l = len[i];
          end else if (st[i].cnt < st[i].len_l) begin
            st_nxt[i].cnt = st[i].cnt + CNT_W'(1);
          end else begin
            st_nxt[i].state = IDLE;
            st_nxt[i].cnt   = '0;
            st_nxt[i].done  = 1'b1;
          end
        end
        default: st_nxt[i].state = IDLE;
      endcase
      if (rst_user) st_nxt[i].armed = 1'b0;
    end
  end

endmodule

// File: tb/tb_generate_ena_write_mc.sv
module tb_generate_ena_write_mc;
  localparam int CH    = 4;
  localparam int CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                rst_user;
  logic [CH-1:0]       d;
  logic [CH*CNT_W-1:0] cfg_len;
  logic [CH-1:0]       cfg_edge;
  logic [CH-1:0]       cfg_retrig;
  logic [CH-1:0]       cfg_skip_first;
  logic [CH-1:0]       q;
  logic [CH-1:0]       busy;
  logic [CH-1:0]       done;

  always #5 clk = ~clk;

  generate_ena_write_mc #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rst_user(rst_user), .d(d),
    .cfg_len(cfg_len), .cfg_edge(cfg_edge), .cfg_retrig(cfg_retrig),
    .cfg_skip_first(cfg_skip_first), .q(q), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each channel is described by the edge index at which its
  // current window ends; q is high while the edge count is below that index.
  longint k;
  longint win_end  [CH];
  bit     armed_m  [CH];
  bit     dprev_m  [CH];
  int     rst_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  function automatic longint len_of(input int i);
    logic [CNT_W-1:0] l;
    l = cfg_len[i*CNT_W +: CNT_W];
    return longint'(l);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      win_end[i] = -1;
      armed_m[i] = 1'b0;
      dprev_m[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    longint l;
    bit     trig;
    bit     active;
    k++;
    for (int i = 0; i < CH; i++) begin
      l      = len_of(i);
      trig   = cfg_edge[i] ? (d[i] && !dprev_m[i]) : d[i];
      active = (k - 1 < win_end[i]);
      if (!active) begin
        if (trig && l != 0) begin
          if (cfg_skip_first[i] && !armed_m[i]) armed_m[i] = 1'b1;
          else win_end[i] = k + l;
        end
      end else if (trig && cfg_retrig[i] && l != 0) begin
        win_end[i] = k + l;
      end
      if (rst_user) armed_m[i] = 1'b0;
      dprev_m[i] = d[i];
    end
  endtask

  task automatic compare_outputs();
    logic [CH-1:0] eq;
    logic [CH-1:0] ed;
    for (int i = 0; i < CH; i++) begin
      eq[i] = (k < win_end[i]);
      ed[i] = (k == win_end[i]);
    end
    check("q", 32'(q), 32'(eq));
    check("busy", 32'(busy), 32'(eq));
    check("done", 32'(done), 32'(ed));
  endtask

  task automatic rand_cfg(input int i);
    if ($urandom_range(0, 7) == 0) cfg_len[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 14));
    else cfg_len[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
    cfg_edge[i]       = 1'($urandom_range(0, 1));
    cfg_retrig[i]     = 1'($urandom_range(0, 1));
    cfg_skip_first[i] = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    k        = 0;
    rst_hold = 0;
    rst_n    = 1'b0;
    rst_user = 1'b0;
    d        = '0;
    cfg_len  = '0;
    cfg_edge = '0;
    cfg_retrig = '0;
    cfg_skip_first = '0;
    for (int i = 0; i < CH; i++) rand_cfg(i);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_q", 32'(q), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      compare_outputs();

      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 3) == 0) d[i] = ~d[i];
        if ($urandom_range(0, 29) == 0) rand_cfg(i);
        else if ($urandom_range(0, 19) == 0)
          cfg_len[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
      end
      rst_user = ($urandom_range(0, 24) == 0);

      if (!rst_n) begin
        if (rst_hold > 0) rst_hold--;
        else rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        rst_hold = 1;
        #1;
        model_reset();
        check("async_rst_q", 32'(q), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
